sar_search_ctrl: RTL and testbench
==================================

// Module: sar_search_ctrl
// PURPOSE
//  Drives a trial operand into an external magnitude comparator (trial on A, target on B).
//  Reads back its LT/EQ/GT result and finds the target by MSB-first successive approximation.
//  Sits on the operand side of the comparator: it produces A and consumes LT/EQ/GT.
//  Takes at most WIDTH cycles; reports the result and whether the comparator ever saw EQ.
// PARAMETERS
//  WIDTH  4  operand width in bits; trial, result and bit index span this range
// PORTS
//  clk     in   1      single clock, rising edge
//  rst     in   1      synchronous reset, active-high
//  start   in   1      one-cycle request to begin a search; sampled only in IDLE
//  LT      in   1      comparator: trial < target (combinational from trial, same cycle)
//  EQ      in   1      comparator: trial == target
//  GT      in   1      comparator: trial > target
//  trial   out  WIDTH  operand driven to comparator input A
//  busy    out  1      high while in TEST
//  done    out  1      one-cycle pulse when a search ends
//  found   out  1      valid with done, held after: EQ was observed
//  err     out  1      valid with done, held after: illegal LT/EQ/GT code observed
//  result  out  WIDTH  valid with done; held until the next accepted start
// BEHAVIOUR
//  Reset (rst=1 at clk edge, any state, including mid-search):
//   - state=IDLE; acc=0; idx=WIDTH-1.
//   - trial=0, busy=0, done=0, found=0, err=0, result=0.
//  States:
//   - IDLE: start=1 -> TEST; acc=0, idx=WIDTH-1, clear found/err.
//   - TEST: busy=1; trial = acc | (1<<idx), combinational from registers.
//   - DONE: done=1 for exactly one cycle, then unconditionally -> IDLE.
//   - Outside TEST, trial=0.
//  TEST, sampled each clk; priority top-down:
//   - Code not one-hot (none or >1 of LT/EQ/GT): err=1, found=0, result=acc -> DONE.
//   - EQ: result=trial, found=1 -> DONE (early exit).
//   - GT: bit idx stays 0 in acc.
//   - LT: acc[idx] set to 1.
//   - GT/LT with idx==0: result = updated acc, found=0 -> DONE; else idx-1, stay TEST.
//  Latency:
//   - Start accepted at edge N -> first trial visible in cycle N+1.
//   - done at the latest in cycle N+1+WIDTH (WIDTH TEST cycles + DONE).
//   - An EQ on the k-th trial gives done in cycle N+1+k.
//  Boundaries:
//   - Any nonzero target reaches EQ by the last bit.
//   - Target 0: every trial GT -> result=0, found=0, err=0 (defined zero case, not an error).
//   - Target all-ones: LT on every bit, EQ on the final trial.
//   - start while busy or in DONE: ignored, no queuing.
//   - start and rst in the same cycle: rst wins.
//   - found/err/result stay stable from DONE until the next accepted start.
//  Width rules:
//   - idx is $clog2(WIDTH) bits; trial/acc/result are WIDTH bits.
//   - No arithmetic beyond the bit-set/OR.
// STRUCTURE
//  Shared package sar_pkg:
//   - state typedef {IDLE, TEST, DONE}.
//   - Comparator result code constants CMP_LT=3'b100, CMP_EQ=3'b010, CMP_GT=3'b001.
//  Single module: one registered FSM plus acc/idx registers; no sub-module.
//  The comparator is external, instantiated beside this block in the bench/top.
// TESTING
//  The bench instantiates the team 4-bit comparator with A=trial, B=target; WIDTH=4.
//  1 target=4'b0101, start:
//    trials 1000(GT), 0100(LT), 0110(GT), 0101(EQ) -> done in 4th cycle after trial starts,
//    result=5, found=1.
//  2 target=4'b0000: trials 1000, 0100, 0010, 0001 all GT -> result=0, found=0, err=0.
//  3 target=4'b1000: first trial EQ -> done next cycle, result=8, found=1, busy for 1 cycle.
//  4 target=4'b1111: LT,LT,LT then EQ on 1111 -> result=15, found=1.
//  5 Force LT=EQ=GT=0 on the 2nd trial -> err=1, found=0, result=4'b0000 (acc after GT on bit 3).
//  6 Disturbances:
//    - rst mid-search (after 2 trials) -> next cycle all outputs 0, IDLE.
//    - start pulsed while busy -> ignored.
//    - A fresh start afterwards completes normally.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types and comparator result codes for the successive-approximation search controller.
// Codes are packed as {LT, EQ, GT}.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] CMP_LT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_GT = 3'b001;

    // A comparator code is legal only when exactly one of LT/EQ/GT is asserted.
    function automatic logic cmp_legal(input logic [2:0] code);
        return (code == CMP_LT) || (code == CMP_EQ) || (code == CMP_GT);
    endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// MSB-first successive-approximation search driving an external magnitude comparator.
// The trial goes out on comparator input A, and the LT/EQ/GT result comes back in the same cycle.
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             LT,
    input  logic             EQ,
    input  logic             GT,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Handshake: start is sampled only in IDLE, and any start seen in TEST or DONE is dropped.
    // done pulses for one cycle. found, err and result stay valid from then until the next accepted start.
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               found_q, found_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [2:0]         code;
    logic [WIDTH-1:0]   trial_w;
    logic [WIDTH-1:0]   acc_upd;

    assign code    = {LT, EQ, GT};
    assign trial_w = acc_q | (WIDTH'(1) << idx_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            idx_q    <= IDX_W'(WIDTH - 1);
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            found_q  <= found_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        found_d  = found_q;
        err_d    = err_q;
        result_d = result_q;
        acc_upd  = acc_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = TEST;
                    acc_d   = '0;
                    idx_d   = IDX_W'(WIDTH - 1);
                    found_d = 1'b0;
                    err_d   = 1'b0;
                end
            end

            TEST: begin
                if (!cmp_legal(code)) begin
                    err_d    = 1'b1;
                    found_d  = 1'b0;
                    result_d = acc_q;
                    state_d  = DONE;
                end else if (code == CMP_EQ) begin
                    result_d = trial_w;
                    found_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    // LT keeps the trial bit. GT leaves it clear in the accumulator.
                    acc_upd = (code == CMP_LT) ? trial_w : acc_q;
                    acc_d   = acc_upd;
                    if (idx_q == '0) begin
                        result_d = acc_upd;
                        found_d  = 1'b0;
                        state_d  = DONE;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = (state_q == TEST);
    assign done   = (state_q == DONE);
    assign trial  = busy ? trial_w : '0;
    assign found  = found_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl with a behavioural comparator beside the DUT.
// The reference model derives the trial sequence and outcome from the target value.
module tb_sar_search_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic         lt, eq, gt;
    logic [W-1:0] trial;
    logic         busy, done, found, err;
    logic [W-1:0] result;

    logic [W-1:0] target;
    logic         ovr;
    logic [2:0]   ovr_code;

    int n_tests;
    int n_fail;

    logic [W-1:0] exp_q[$];

    // Comparator: A = trial, B = target, optionally overridden with an illegal code.
    assign lt = ovr ? ovr_code[2] : (trial < target);
    assign eq = ovr ? ovr_code[1] : (trial == target);
    assign gt = ovr ? ovr_code[0] : (trial > target);

    sar_search_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .LT     (lt),
        .EQ     (eq),
        .GT     (gt),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .err    (err),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Number of trials for a legal search: the search ends on the lowest set bit, or after every bit when the target is 0.
    function automatic int trials_for(input logic [W-1:0] t);
        int lsb;
        if (t == 0) return W;
        lsb = 0;
        while (((int'(t) >> lsb) & 1) == 0) lsb++;
        return W - lsb;
    endfunction

    // The j-th trial (1-based) keeps the target's bits above position W-j and sets bit W-j.
    function automatic logic [W-1:0] trial_for(input logic [W-1:0] t, input int j);
        int b;
        int v;
        b = W - j;
        v = (int'(t) & ~((1 << (b + 1)) - 1)) | (1 << b);
        return W'(v);
    endfunction

    // err_at: the busy cycle on which the comparator code is corrupted (0 = none).
    // noise_at: the busy cycle on which a stray start is pulsed (0 = none).
    task automatic run_search(input logic [W-1:0] t, input int err_at, input logic [2:0] bad,
                              input int noise_at);
        int k, n_tr, cyc, busy_cnt;
        logic [W-1:0] exp_res;
        logic exp_found, exp_err;
        logic seen_done;

        k = trials_for(t);
        if (err_at > 0 && err_at <= k) begin
            n_tr      = err_at;
            exp_err   = 1'b1;
            exp_found = 1'b0;
            exp_res   = W'(int'(t) & ~((1 << (W - err_at + 1)) - 1));
        end else begin
            n_tr      = k;
            exp_err   = 1'b0;
            exp_found = (t != 0);
            exp_res   = t;
        end
        exp_q.delete();
        for (int j = 1; j <= n_tr; j++) exp_q.push_back(trial_for(t, j));

        target = t;
        start  = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        cyc       = 1;
        busy_cnt  = 0;
        seen_done = 1'b0;
        while (cyc <= W + 3) begin
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (busy) begin
                busy_cnt++;
                if (exp_q.size() == 0) check("extra_trial", trial, 0);
                else check("trial", trial, exp_q.pop_front());
                if (busy_cnt == err_at) begin
                    ovr      = 1'b1;
                    ovr_code = bad;
                end
                if (busy_cnt == noise_at) start = 1'b1;
            end
            @(posedge clk);
            #1;
            ovr   = 1'b0;
            start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("done_seen", seen_done, 1);
        check("done_cycle", cyc, n_tr + 1);
        check("busy_cycles", busy_cnt, n_tr);
        check("busy_in_done", busy, 0);
        check("trial_in_done", trial, 0);
        check("found", found, exp_found);
        check("err", err, exp_err);
        check("result", result, exp_res);
        @(negedge clk);
        check("done_pulse", done, 0);
        repeat (2) @(negedge clk);
        check("found_held", found, exp_found);
        check("err_held", err, exp_err);
        check("result_held", result, exp_res);
    endtask

    initial begin
        logic [2:0] bad_codes[5];
        int r;
        bad_codes[0] = 3'b000; bad_codes[1] = 3'b011; bad_codes[2] = 3'b101;
        bad_codes[3] = 3'b110; bad_codes[4] = 3'b111;

        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        target   = '0;
        ovr      = 1'b0;
        ovr_code = 3'b000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_trial", trial, 0);
        check("rst_found", found, 0);
        check("rst_err", err, 0);
        check("rst_result", result, 0);

        // Directed searches.
        run_search(4'b0101, 0, 3'b000, 0);
        run_search(4'b0000, 0, 3'b000, 0);
        run_search(4'b1000, 0, 3'b000, 0);
        run_search(4'b1111, 0, 3'b000, 0);
        run_search(4'b0101, 2, 3'b000, 0);

        // Reset mid-search after two trials.
        target = 4'b1001;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_trial", trial, 0);
        check("midrst_found", found, 0);
        check("midrst_err", err, 0);
        check("midrst_result", result, 0);

        // start together with rst is dropped.
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_busy", busy, 0);

        // A stray start while busy is ignored, and the search still completes normally.
        run_search(4'b1001, 0, 3'b000, 2);

        // A start seen in the DONE cycle is ignored.
        target = 4'b1000;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("done_cycle_d", done, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done_busy", busy, 0);
        @(negedge clk);
        check("start_in_done_idle", busy, 0);

        // Fresh search afterwards.
        run_search(4'b0011, 0, 3'b000, 0);

        // Randomized searches with occasional illegal codes and stray starts.
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 3);
            run_search(W'($urandom_range(0, 15)),
                       (r == 0) ? $urandom_range(1, W) : 0,
                       bad_codes[$urandom_range(0, 4)],
                       (r == 1) ? $urandom_range(1, W) : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
